frame_window_reader: RTL
========================

// Module: frame_window_reader
// PURPOSE
//  Single-port BRAM frame buffer controller, successor of the LOAD/GET frame controller.
//  Loads one IMAGE_WIDTH x IMAGE_HEIGHT frame from the uBlaze-side stream.
//  Serves it to the convolution datapath as a column-strip KERNEL_SIZE-wide window sweep.
//  Can also dump it linearly back to the uBlaze side.
//  Sits between the file_register interface and the kernel/processing engine.
// PARAMETERS
//  PIXEL_WIDTH   8   pixel/RAM data width
//  IMAGE_WIDTH   10  frame width in pixels (W)
//  IMAGE_HEIGHT  10  frame height in pixels (H)
//  KERNEL_SIZE   3   window width K; elaboration error unless 1<=K<=W
//  ADDR_WIDTH    16  RAM address width; elaboration error unless 2**ADDR_WIDTH >= W*H
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  i_start_load   in   1       request frame load (IDLE or READY)
//  i_load_valid   in   1       i_load_data valid this cycle
//  i_load_data    in   PW      pixel to store
//  i_start_kernel in   1       request window sweep (READY only)
//  i_start_dump   in   1       request linear dump (READY only)
//  i_rd_ready     in   1       downstream accepts o_rd_data
//  o_rd_valid     out  1       o_rd_data valid
//  o_rd_data      out  PW      pixel read from RAM
//  o_rd_eol       out  1       last pixel of a K-pixel row chunk (kernel mode; 0 in dump)
//  o_rd_last      out  1       final pixel of current sweep/dump
//  o_frame_ready  out  1       state==READY
//  o_busy         out  1       state is LOAD, KERNEL or DUMP
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, all outputs 0; RAM contents not cleared.
//  Reset mid-operation: abort immediately to IDLE, in-flight read discarded (o_rd_valid=0).
//  States: IDLE, LOAD, READY, KERNEL, DUMP. N = W*H.
//  IDLE: i_start_load -> LOAD, waddr=0. Other starts ignored.
//  LOAD: each cycle with i_load_valid writes i_load_data at waddr, waddr++.
//   - Gaps (valid=0) hold waddr.
//   - Write of waddr N-1 -> READY next cycle.
//   - i_start_* ignored in LOAD.
//  READY: priority load > kernel > dump.
//   - Reload overwrites the frame.
//   - Simultaneous starts: highest priority wins, others dropped.
//  KERNEL: for c=0..W-K, r=0..H-1, k=0..K-1 (k fastest): addr = row_base + c + k.
//   - row_base steps by W per row; no multiplier.
//   - Total (W-K+1)*H*K pixels.
//   - o_rd_eol=1 when k==K-1; o_rd_last=1 on the final element.
//   - After its handshake -> READY (frame kept, sweep repeatable).
//  DUMP: addr 0..N-1 linear.
//   - o_rd_last on addr N-1.
//   - After its handshake -> IDLE (frame consumed).
//  Read pipeline (stall-enable, 1-cycle latency, full throughput):
//   - adv = !o_rd_valid || i_rd_ready.
//   - RAM en = adv; address counters advance only on adv.
//   - o_rd_valid/eol/last registered on adv.
//   - RAM no-change output holds o_rd_data while stalled.
//   - Handshake = o_rd_valid && i_rd_ready.
//   - No pixel dropped or duplicated under any i_rd_ready pattern.
//   - Issue stops after the last address; the state exits on the last handshake.
//  Counters sized with clog2 of W, H, K, N; addr arithmetic in ADDR_WIDTH, no wrap (max N-1).
// STRUCTURE
//  Shared package/header: state localparams (3-bit), clog2 function, mode enum (KERNEL/DUMP).
//  Sub-module frame_ram_sp: single-port no-change BRAM (clka, ena, wea, addra, dina, douta).
//   - Inferred.
//   - Write and read never in the same cycle.
//  Controller: FSM + address generator (c, r, k, row_base) + output valid pipeline.
// TESTING
//  Load 10x10 pixel=addr, contiguous valid -> o_frame_ready after 100 writes.
//   - Dump reads 0..99, o_rd_last at 99, then IDLE.
//  Load with valid toggling every other cycle -> same stored frame; dump identical 0..99.
//  Kernel sweep, ready=1 -> 240 pixels.
//   - Starts 0,1,2,10,11,12,20,...
//   - Strip c=1 starts at 1; ends 97,98,99.
//   - eol every 3rd pixel; last at 99; back to READY.
//  Kernel sweep with i_rd_ready random 50% -> identical 240-pixel sequence, data stable while stalled.
//  READY with start_kernel & start_dump same cycle -> kernel sweep; second start_kernel repeats sweep.
//  Reset at waddr 37 during LOAD -> IDLE, outputs 0.
//   - Reset during KERNEL with o_rd_valid=1 -> o_rd_valid=0 next cycle.
//   - Reload then succeeds.

Source files
------------

// File: rtl/frame_window_reader_pkg.sv
// Shared types and helpers for the frame window reader.
// State encodings, read-mode enum and width helper.
package frame_window_reader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_READY  = 3'd2;
    localparam logic [2:0] ST_KERNEL = 3'd3;
    localparam logic [2:0] ST_DUMP   = 3'd4;

    typedef enum logic {
        MODE_KERNEL = 1'b0,
        MODE_DUMP   = 1'b1
    } mode_e;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/frame_window_reader_ram.sv
// Single-port no-change frame RAM.
// Output holds its last read while disabled or writing.
module frame_ram_sp
    import frame_window_reader_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DEPTH = 100
) (
    input  logic          clka,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta
);

    localparam int IW = clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] idx;
    logic          unused_addr;

    assign idx         = addra[IW-1:0];
    assign unused_addr = ^addra;

    // Write, or read into the output latch; never both.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[idx] <= dina;
            else     douta    <= mem[idx];
        end
    end

endmodule

// File: rtl/frame_window_reader.sv
// Frame buffer controller: load, K-wide column-strip sweep, dump.
// One-cycle stall-enabled read pipeline in front of the RAM.
module frame_window_reader
    import frame_window_reader_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_SIZE  = 3,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start_load,
    input  logic                   i_load_valid,
    input  logic [PIXEL_WIDTH-1:0] i_load_data,
    input  logic                   i_start_kernel,
    input  logic                   i_start_dump,
    input  logic                   i_rd_ready,
    output logic                   o_rd_valid,
    output logic [PIXEL_WIDTH-1:0] o_rd_data,
    output logic                   o_rd_eol,
    output logic                   o_rd_last,
    output logic                   o_frame_ready,
    output logic                   o_busy
);

    localparam int N  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW = ADDR_WIDTH;
    localparam int NW = clog2(N);
    localparam int CW = clog2(IMAGE_WIDTH);
    localparam int RW = clog2(IMAGE_HEIGHT);
    localparam int KW = clog2(KERNEL_SIZE);

    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMAGE_WIDTH - KERNEL_SIZE);
    localparam logic [RW-1:0] R_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_SIZE - 1);

    if (KERNEL_SIZE < 1 || KERNEL_SIZE > IMAGE_WIDTH) begin : g_bad_k
        $error("KERNEL_SIZE must be within 1..IMAGE_WIDTH");
    end
    if ((longint'(1) << ADDR_WIDTH) < longint'(N)) begin : g_bad_aw
        $error("ADDR_WIDTH too small for the frame");
    end

    logic [2:0]             state_q, state_d;
    logic [NW-1:0]          lin_q;
    logic [CW-1:0]          c_q;
    logic [RW-1:0]          r_q;
    logic [KW-1:0]          k_q;
    logic [AW-1:0]          base_q;
    logic                   done_q;
    logic                   valid_q, eol_q, last_q;
    logic                   in_rd, adv, rd_issue, we, ram_en;
    logic                   k_end, r_end, c_end, issue_last;
    logic                   rd_end;
    logic [AW-1:0]          kaddr, ram_addr;
    logic [PIXEL_WIDTH-1:0] ram_q;
    mode_e                  mode;

    // Address selection and pipeline advance.
    always_comb begin
        in_rd    = (state_q == ST_KERNEL) || (state_q == ST_DUMP);
        mode     = (state_q == ST_DUMP) ? MODE_DUMP : MODE_KERNEL;
        adv      = !valid_q || i_rd_ready;
        rd_issue = in_rd && !done_q && adv;
        we       = (state_q == ST_LOAD) && i_load_valid;
        ram_en   = we || rd_issue;
        k_end    = (k_q == K_LAST);
        r_end    = (r_q == R_LAST);
        c_end    = (c_q == C_LAST);
        kaddr    = base_q + AW'(c_q) + AW'(k_q);
        ram_addr = (state_q == ST_KERNEL) ? kaddr : AW'(lin_q);
        if (mode == MODE_DUMP) issue_last = (lin_q == N_LAST);
        else                   issue_last = k_end && r_end && c_end;
        rd_end   = valid_q && i_rd_ready && last_q;
    end

    // Next-state decode; load beats kernel beats dump in READY.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start_load) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (we && lin_q == N_LAST) state_d = ST_READY;
            end
            ST_READY: begin
                if (i_start_load)        state_d = ST_LOAD;
                else if (i_start_kernel) state_d = ST_KERNEL;
                else if (i_start_dump)   state_d = ST_DUMP;
            end
            ST_KERNEL: begin
                if (rd_end) state_d = ST_READY;
            end
            ST_DUMP: begin
                if (rd_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Address counters: cleared on every state change.
    always_ff @(posedge clk) begin
        if (reset || state_d != state_q) begin
            lin_q  <= '0;
            c_q    <= '0;
            r_q    <= '0;
            k_q    <= '0;
            base_q <= '0;
            done_q <= 1'b0;
        end else if (we) begin
            lin_q <= lin_q + 1'b1;
        end else if (rd_issue) begin
            if (issue_last) begin
                done_q <= 1'b1;
            end else if (mode == MODE_DUMP) begin
                lin_q <= lin_q + 1'b1;
            end else if (!k_end) begin
                k_q <= k_q + 1'b1;
            end else begin
                k_q <= '0;
                if (!r_end) begin
                    r_q    <= r_q + 1'b1;
                    base_q <= base_q + AW'(IMAGE_WIDTH);
                end else begin
                    r_q    <= '0;
                    base_q <= '0;
                    c_q    <= c_q + 1'b1;
                end
            end
        end
    end

    // Output flags follow the RAM read by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
        end else if (adv) begin
            valid_q <= rd_issue;
            eol_q   <= rd_issue && (mode == MODE_KERNEL) && k_end;
            last_q  <= rd_issue && issue_last;
        end
    end

    frame_ram_sp #(
        .DW    (PIXEL_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (N)
    ) u_ram (
        .clka  (clk),
        .ena   (ram_en),
        .wea   (we),
        .addra (ram_addr),
        .dina  (i_load_data),
        .douta (ram_q)
    );

    assign o_rd_valid    = valid_q;
    assign o_rd_data     = valid_q ? ram_q : '0;
    assign o_rd_eol      = eol_q;
    assign o_rd_last     = last_q;
    assign o_frame_ready = (state_q == ST_READY);
    assign o_busy        = (state_q == ST_LOAD) || in_rd;

endmodule
